// File: rtl/bla_pkg.sv
// Shared types for the polyline rasteriser: FSM states, coordinate
// bundle and packed-vertex slicing helpers.
package bla_pkg;

  localparam int DEF_COORD_W  = 8;
  localparam int DEF_MAX_VERT = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SKIP,
    S_STEP,
    S_DONE
  } state_e;

  typedef struct packed {
    logic [DEF_COORD_W-1:0] y;
    logic [DEF_COORD_W-1:0] x;
  } coord_t;

  function automatic int vert_w(input int cw);
    return 2 * cw;
  endfunction

  function automatic int vert_lsb(input int i, input int cw);
    return 2 * cw * i;
  endfunction

endpackage

// File: rtl/bresenham_core.sv
// All-octant Bresenham walker: holds the current point, the edge end
// and the error terms; exposes a look-ahead match against the end point.
module bresenham_core #(
  parameter int COORD_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic               adv_i,
  input  logic [COORD_W-1:0] x0_i,
  input  logic [COORD_W-1:0] y0_i,
  input  logic [COORD_W-1:0] x1_i,
  input  logic [COORD_W-1:0] y1_i,
  output logic [COORD_W-1:0] x_o,
  output logic [COORD_W-1:0] y_o,
  output logic               at_end_o,
  output logic               nxt_end_o
);

  localparam int SW = COORD_W + 2;
  typedef logic [COORD_W-1:0] crd_t;
  localparam crd_t ONE = crd_t'(1);

  logic signed [SW-1:0] err_q, err_d, dx_q, dy_q;
  logic signed [SW-1:0] ddx, ddy, adx, ndy;
  logic signed [SW:0]   e2, dxe, dye;
  logic                 sx_q, sy_q;
  crd_t                 x_q, y_q, xe_q, ye_q, nx, ny;

  assign ddx = $signed({2'b00, x1_i}) - $signed({2'b00, x0_i});
  assign ddy = $signed({2'b00, y1_i}) - $signed({2'b00, y0_i});
  assign adx = ddx[SW-1] ? -ddx : ddx;
  assign ndy = ddy[SW-1] ? ddy : -ddy;

  // Both tests use the pre-step error, so diagonal moves apply both.
  always_comb begin
    e2    = {err_q, 1'b0};
    dxe   = {dx_q[SW-1], dx_q};
    dye   = {dy_q[SW-1], dy_q};
    err_d = err_q;
    nx    = x_q;
    ny    = y_q;
    if (e2 >= dye) begin
      err_d = err_d + dy_q;
      nx    = sx_q ? x_q - ONE : x_q + ONE;
    end
    if (e2 <= dxe) begin
      err_d = err_d + dx_q;
      ny    = sy_q ? y_q - ONE : y_q + ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q   <= '0;
      y_q   <= '0;
      xe_q  <= '0;
      ye_q  <= '0;
      sx_q  <= 1'b0;
      sy_q  <= 1'b0;
      dx_q  <= '0;
      dy_q  <= '0;
      err_q <= '0;
    end else if (load_i) begin
      x_q   <= x0_i;
      y_q   <= y0_i;
      xe_q  <= x1_i;
      ye_q  <= y1_i;
      sx_q  <= ddx[SW-1];
      sy_q  <= ddy[SW-1];
      dx_q  <= adx;
      dy_q  <= ndy;
      err_q <= adx + ndy;
    end else if (adv_i) begin
      x_q   <= nx;
      y_q   <= ny;
      err_q <= err_d;
    end
  end

  assign x_o       = x_q;
  assign y_o       = y_q;
  assign at_end_o  = (x_q == xe_q) && (y_q == ye_q);
  assign nxt_end_o = (nx == xe_q) && (ny == ye_q);

endmodule

// File: rtl/bla_poly_engine.sv
// Polyline rasteriser: walks the edge list of a latched primitive and
// streams pixels over a valid/ready handshake.
module bla_poly_engine
  import bla_pkg::*;
#(
  parameter int COORD_W  = DEF_COORD_W,
  parameter int MAX_VERT = DEF_MAX_VERT,
  parameter int VCNT_W   = $clog2(MAX_VERT + 1)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            bla_en,
  input  logic [VCNT_W-1:0]               vertex_count,
  input  logic                            closed,
  input  logic [2*COORD_W*MAX_VERT-1:0]   coordinates,
  output logic                            pix_valid,
  input  logic                            pix_ready,
  output logic [COORD_W-1:0]              pix_x,
  output logic [COORD_W-1:0]              pix_y,
  output logic                            busy,
  output logic                            bla_done,
  output logic                            bla_err
);

  localparam int VW = 2 * COORD_W;
  typedef logic [VCNT_W-1:0] cnt_t;
  localparam cnt_t ONE = cnt_t'(1);
  localparam cnt_t TWO = cnt_t'(2);

  state_e state_q, state_d;
  cnt_t   k_q, k_d, n_q, last_k, kn;
  logic   closed_q, err_q, err_d, closing;
  logic   load, adv, at_end, nxt_end, bad_cnt;
  logic [VW*MAX_VERT-1:0] coords_q;
  logic [VW-1:0]          va, vb;

  assign kn = (k_q == n_q - ONE) ? '0 : k_q + ONE;
  assign va = coords_q[vert_lsb(int'(k_q), COORD_W) +: VW];
  assign vb = coords_q[vert_lsb(int'(kn), COORD_W) +: VW];

  assign bad_cnt = (vertex_count == '0) ||
                   (vertex_count > cnt_t'(MAX_VERT));

  // Closing edge exists only for n>=3 and is always the last one.
  assign closing = closed_q && (n_q > TWO) && (k_q == n_q - ONE);

  always_comb begin
    last_k = '0;
    if (n_q > TWO)
      last_k = closed_q ? n_q - ONE : n_q - TWO;
  end

  bresenham_core #(.COORD_W(COORD_W)) u_core (
    .clk       (clk),
    .rst       (rst),
    .load_i    (load),
    .adv_i     (adv),
    .x0_i      (va[COORD_W-1:0]),
    .y0_i      (va[VW-1:COORD_W]),
    .x1_i      (vb[COORD_W-1:0]),
    .y1_i      (vb[VW-1:COORD_W]),
    .x_o       (pix_x),
    .y_o       (pix_y),
    .at_end_o  (at_end),
    .nxt_end_o (nxt_end)
  );

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    err_d   = err_q;
    load    = 1'b0;
    adv     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bla_en) begin
          k_d     = '0;
          err_d   = bad_cnt;
          state_d = bad_cnt ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        load    = 1'b1;
        state_d = (k_q != '0) ? S_SKIP : S_STEP;
      end
      S_SKIP: begin
        if (at_end) begin
          state_d = (k_q == last_k) ? S_DONE : S_LOAD;
          k_d     = (k_q == last_k) ? k_q : k_q + ONE;
        end else if (closing && nxt_end) begin
          state_d = S_DONE;
        end else begin
          adv     = 1'b1;
          state_d = S_STEP;
        end
      end
      S_STEP: begin
        if (pix_ready) begin
          if (at_end) begin
            state_d = (k_q == last_k) ? S_DONE : S_LOAD;
            k_d     = (k_q == last_k) ? k_q : k_q + ONE;
          end else if (closing && nxt_end) begin
            state_d = S_DONE;
          end else begin
            adv = 1'b1;
          end
        end
      end
      S_DONE: begin
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      k_q      <= '0;
      n_q      <= '0;
      closed_q <= 1'b0;
      err_q    <= 1'b0;
      coords_q <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      err_q   <= err_d;
      if (state_q == S_IDLE && bla_en) begin
        n_q      <= vertex_count;
        closed_q <= closed;
        coords_q <= coordinates;
      end
    end
  end

  assign pix_valid = (state_q == S_STEP);
  assign busy      = (state_q != S_IDLE);
  assign bla_done  = (state_q == S_DONE);
  assign bla_err   = (state_q == S_DONE) && err_q;

endmodule
